video_testgen: RTL and testbench

VIDEO_TESTGEN -- requirements
Module: video_testgen

---
 rtl/video_testgen_pkg.sv | 48 ++++
 rtl/video_timing_counter.sv | 68 ++++++
 rtl/video_testgen.sv | 133 +++++++++++++
 tb/tb_video_testgen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/video_testgen_pkg.sv
// video_testgen_pkg: shared types and constants for the video test-pattern generator.
//   cnt_t     - pixel/line counter type (covers totals up to 4095)
//   pattern_e - encoding of the pattern_sel input
//   RGB_*     - 24-bit {R,G,B} colour constants
//   bar_color - colour of colour-bar index 0..7, left to right
package video_testgen_pkg;

  localparam int unsigned CNT_W = 12;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    PAT_BARS    = 3'd0,
    PAT_RAMP    = 3'd1,
    PAT_CHECKER = 3'd2,
    PAT_SOLID   = 3'd3,
    PAT_BORDER  = 3'd4,
    PAT_BLACK5  = 3'd5,
    PAT_BLACK6  = 3'd6,
    PAT_BLACK7  = 3'd7
  } pattern_e;

  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;
  localparam logic [23:0] RGB_GREY    = 24'h202020;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    c = RGB_BLACK;
    case (idx)
      3'd0: c = RGB_WHITE;
      3'd1: c = RGB_YELLOW;
      3'd2: c = RGB_CYAN;
      3'd3: c = RGB_GREEN;
      3'd4: c = RGB_MAGENTA;
      3'd5: c = RGB_RED;
      3'd6: c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// video_timing_counter: raster position counters and the unregistered timing
// flags derived from the current position.
//   clk, reset (async, active high), ce_pix (advance enable), enable (0 = hold at origin)
//   hcount, vcount - current raster position
//   de, hs, vs     - data enable / syncs for the current position
//   line_end       - hcount is on the last pixel of the line
module video_timing_counter
  import video_testgen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic clk,
  input  logic reset,
  input  logic ce_pix,
  input  logic enable,
  output cnt_t hcount,
  output cnt_t vcount,
  output logic de,
  output logic hs,
  output logic vs,
  output logic line_end
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT  = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT  = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_BEG = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_BEG = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (ce_pix) begin
      if (!enable) begin
        hcount <= '0;
        vcount <= '0;
      end else if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? '0 : vcount + cnt_t'(1);
      end else begin
        hcount <= hcount + cnt_t'(1);
      end
    end
  end

  always_comb begin
    line_end = (hcount == H_LAST);
    de       = (hcount < H_ACT) && (vcount < V_ACT);
    hs       = (hcount >= HS_BEG) && (hcount < HS_END);
    // vcount only moves on the line wrap, so vs changes only at hcount = 0
    vs       = (vcount >= VS_BEG) && (vcount < VS_END);
  end

endmodule

// File: rtl/video_testgen.sv
// video_testgen: VGA-style test-pattern generator with registered outputs.
//   clk, reset (async, active high), ce_pix (pixel enable), enable (0 = idle at origin)
//   pattern_sel - requested pattern, sampled at the frame origin
//   dout        - {R,G,B} pixel, zero outside the active area
//   hs_out, vs_out, de_out - active-high syncs and data enable
//   frame_start - high with the first active pixel of each frame
module video_testgen
  import video_testgen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        enable,
  input  logic [2:0]  pattern_sel,
  output logic [23:0] dout,
  output logic        hs_out,
  output logic        vs_out,
  output logic        de_out,
  output logic        frame_start
);

  localparam cnt_t BAR_LAST   = cnt_t'(H_ACTIVE / 8 - 1);
  localparam cnt_t H_LAST_ACT = cnt_t'(H_ACTIVE - 1);
  localparam cnt_t V_LAST_ACT = cnt_t'(V_ACTIVE - 1);

  cnt_t        hcount;
  cnt_t        vcount;
  logic        de;
  logic        hs;
  logic        vs;
  logic        line_end;
  logic        origin;
  cnt_t        bar_cnt;
  logic [2:0]  bar_idx;
  pattern_e    pat_q;
  pattern_e    pat_cur;
  logic [23:0] color;
  logic [23:0] pixel;

  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk      (clk),
    .reset    (reset),
    .ce_pix   (ce_pix),
    .enable   (enable),
    .hcount   (hcount),
    .vcount   (vcount),
    .de       (de),
    .hs       (hs),
    .vs       (vs),
    .line_end (line_end)
  );

  // The origin pixel uses pattern_sel directly so a whole frame shares one pattern.
  always_comb begin
    origin  = (hcount == '0) && (vcount == '0);
    pat_cur = origin ? pattern_e'(pattern_sel) : pat_q;
    color   = RGB_BLACK;
    case (pat_cur)
      PAT_BARS:    color = bar_color(bar_idx);
      PAT_RAMP:    color = {3{hcount[7:0]}};
      PAT_CHECKER: color = (hcount[3] ^ vcount[3]) ? RGB_WHITE : RGB_BLACK;
      PAT_SOLID:   color = RGB_WHITE;
      PAT_BORDER:  color = (hcount == '0 || hcount == H_LAST_ACT ||
                            vcount == '0 || vcount == V_LAST_ACT) ? RGB_WHITE : RGB_GREY;
      default:     color = RGB_BLACK;
    endcase
    pixel = de ? color : '0;
  end

  // Bar index tracks hcount / (H_ACTIVE/8) with a width counter instead of a divider;
  // it saturates at the last bar through blanking and restarts with each line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bar_cnt <= '0;
      bar_idx <= '0;
      pat_q   <= PAT_BARS;
    end else if (ce_pix) begin
      if (!enable || line_end) begin
        bar_cnt <= '0;
        bar_idx <= '0;
      end else if (bar_cnt == BAR_LAST) begin
        bar_cnt <= '0;
        if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_cnt <= bar_cnt + cnt_t'(1);
      end
      if (enable && origin) pat_q <= pat_cur;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout        <= '0;
      hs_out      <= 1'b0;
      vs_out      <= 1'b0;
      de_out      <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce_pix) begin
      if (!enable) begin
        dout        <= '0;
        hs_out      <= 1'b0;
        vs_out      <= 1'b0;
        de_out      <= 1'b0;
        frame_start <= 1'b0;
      end else begin
        dout        <= pixel;
        hs_out      <= hs;
        vs_out      <= vs;
        de_out      <= de;
        frame_start <= origin;
      end
    end
  end

endmodule

// File: tb/tb_video_testgen.sv
// Scoreboard bench for video_testgen: a driver applies random stimulus each cycle and
// pushes the reference model's expected outputs; a monitor pops and compares after
// every rising edge.
module tb_video_testgen;

  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int HSY = 3;
  localparam int HBP = 3;
  localparam int VA  = 8;
  localparam int VFP = 1;
  localparam int VSY = 1;
  localparam int VBP = 2;
  localparam int HT  = HA + HFP + HSY + HBP;
  localparam int VT  = VA + VFP + VSY + VBP;

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  typedef struct packed {
    logic [23:0] dout;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        ce_pix;
  logic        enable;
  logic [2:0]  pattern_sel;
  logic [23:0] dout;
  logic        hs_out;
  logic        vs_out;
  logic        de_out;
  logic        frame_start;

  exp_t expq[$];
  int   n_chk;
  int   n_fail;

  // reference model state: linear position within the frame, latched pattern, held outputs
  int         mp;
  logic [2:0] mpat;
  exp_t       cur;

  video_testgen #(
    .H_ACTIVE (HA),  .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
    .V_ACTIVE (VA),  .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ce_pix      (ce_pix),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .dout        (dout),
    .hs_out      (hs_out),
    .vs_out      (vs_out),
    .de_out      (de_out),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t ref_pixel(int h, int v, logic [2:0] p);
    exp_t       e;
    logic [7:0] lv;
    e    = '0;
    e.de = (h < HA) && (v < VA);
    e.hs = (h >= HA + HFP) && (h < HA + HFP + HSY);
    e.vs = (v >= VA + VFP) && (v < VA + VFP + VSY);
    e.fs = (h == 0) && (v == 0);
    if (e.de) begin
      case (p)
        3'd0: e.dout = BARS[h / (HA / 8)];
        3'd1: begin lv = 8'(h); e.dout = {lv, lv, lv}; end
        3'd2: e.dout = (((h / 8) + (v / 8)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
        3'd3: e.dout = 24'hFFFFFF;
        3'd4: e.dout = (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) ? 24'hFFFFFF : 24'h202020;
        default: e.dout = 24'h000000;
      endcase
    end
    return e;
  endfunction

  task automatic step(input logic r, input logic en, input logic ce, input logic [2:0] sel);
    int h;
    int v;
    reset       = r;
    enable      = en;
    ce_pix      = ce;
    pattern_sel = sel;
    if (r) begin
      mp   = 0;
      mpat = 3'd0;
      cur  = '0;
    end else if (ce) begin
      if (!en) begin
        mp  = 0;
        cur = '0;
      end else begin
        h = mp % HT;
        v = mp / HT;
        if (h == 0 && v == 0) mpat = sel;
        cur = ref_pixel(h, v, mpat);
        mp  = (mp + 1) % (HT * VT);
      end
    end
    expq.push_back(cur);
    @(negedge clk);
  endtask

  // monitor
  always begin
    exp_t e;
    exp_t a;
    @(posedge clk);
    #1;
    a = '{dout: dout, hs: hs_out, vs: vs_out, de: de_out, fs: frame_start};
    n_chk++;
    if (expq.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty t=%0t: got dout=%06h with no expected entry", $time, a.dout);
    end else begin
      e = expq.pop_front();
      if (a !== e) begin
        n_fail++;
        $display("FAIL pix t=%0t: got dout=%06h hs=%b vs=%b de=%b fs=%b, expected dout=%06h hs=%b vs=%b de=%b fs=%b",
                 $time, a.dout, a.hs, a.vs, a.de, a.fs, e.dout, e.hs, e.vs, e.de, e.fs);
      end
    end
  end

  initial begin
    logic [2:0] sel;
    logic       en;
    n_chk  = 0;
    n_fail = 0;
    mp     = 0;
    mpat   = 3'd0;
    cur    = '0;
    sel    = 3'd0;

    // reset, then continuous ce_pix with colour bars
    step(1'b1, 1'b0, 1'b0, 3'd0);
    step(1'b1, 1'b1, 1'b1, 3'd0);
    step(1'b1, 1'b1, 1'b1, 3'd0);
    repeat (600) step(1'b0, 1'b1, 1'b1, 3'd0);

    // random pattern changes at arbitrary times
    repeat (1200) begin
      if ($urandom_range(0, 59) == 0) sel = 3'($urandom_range(0, 7));
      step(1'b0, 1'b1, 1'b1, sel);
    end

    // strictly alternating ce_pix, then random ce_pix
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'(i % 2 == 0), sel);
    repeat (1500) begin
      if ($urandom_range(0, 79) == 0) sel = 3'($urandom_range(0, 7));
      step(1'b0, 1'b1, 1'($urandom_range(0, 2) != 0), sel);
    end

    // enable toggling with ce_pix held high
    en = 1'b1;
    repeat (800) begin
      if ($urandom_range(0, 79) == 0) en = ~en;
      step(1'b0, en, 1'b1, sel);
    end

    // reset in the middle of line 3, pixel 7
    for (int i = 0; i < 400 && mp != 3 * HT + 7; i++) step(1'b0, 1'b1, 1'b1, sel);
    step(1'b1, 1'b1, 1'b1, sel);
    step(1'b1, 1'b1, 1'b1, sel);
    repeat (400) step(1'b0, 1'b1, 1'b1, sel);

    // random short resets with random ce_pix
    repeat (800) begin
      if ($urandom_range(0, 59) == 0) sel = 3'($urandom_range(0, 7));
      step(1'($urandom_range(0, 199) == 0), 1'b1, 1'($urandom_range(0, 3) != 0), sel);
    end

    step(1'b0, 1'b1, 1'b1, sel);
    step(1'b0, 1'b1, 1'b1, sel);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
